// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Debounces one active-low push-button into a stable level plus
//            single-cycle press/release/any-edge pulses. The raw pin is
//            synchronised, edge-detected and must then stay stable for
//            CNT_MAX cycles before a change of level is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int CNT_MAX     = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS
) (
  input  logic Clk,
  input  logic Rst,
  input  logic key_in,
  output logic key_flag,
  output logic key_press,
  output logic key_release,
  output logic key_state
);

  // Counter only has to reach CNT_MAX-1, so $clog2(CNT_MAX) bits suffice.
  localparam int               CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // released and stable
    ST_FILTER0 = 2'd1,  // falling edge seen, waiting for a stable low
    ST_DOWN    = 2'd2,  // pressed and stable
    ST_FILTER1 = 2'd3   // rising edge seen, waiting for a stable high
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_s1_q, key_s1_d;
  logic             key_s2_q, key_s2_d;
  logic             key_d_q, key_d_d;
  logic             key_flag_q, key_flag_d;
  logic             key_press_q, key_press_d;
  logic             key_release_q, key_release_d;
  logic             key_state_q, key_state_d;
  logic             nedge;
  logic             pedge;

  // Two-flop synchroniser followed by one delay stage for edge detection.
  always_comb begin
    key_s1_d = key_in;
    key_s2_d = key_s1_q;
    key_d_d  = key_s2_q;
    nedge    = ~key_s2_q & key_d_q;
    pedge    = key_s2_q & ~key_d_q;
  end

  // Filter FSM: an opposite edge while filtering aborts without a pulse and
  // takes priority over the counter reaching its terminal value.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    key_flag_d    = 1'b0;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    key_state_d   = key_state_q;
    case (state_q)
      ST_IDLE: begin
        if (nedge) begin
          state_d = ST_FILTER0;
          cnt_d   = '0;
        end
      end
      ST_FILTER0: begin
        if (pedge) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_DOWN;
          key_flag_d  = 1'b1;
          key_press_d = 1'b1;
          key_state_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DOWN: begin
        if (pedge) begin
          state_d = ST_FILTER1;
          cnt_d   = '0;
        end
      end
      ST_FILTER1: begin
        if (nedge) begin
          state_d = ST_DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = ST_IDLE;
          key_flag_d    = 1'b1;
          key_release_d = 1'b1;
          key_state_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // All state and registered outputs; reset returns the pin pipeline to idle-high.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      key_s1_q      <= 1'b1;
      key_s2_q      <= 1'b1;
      key_d_q       <= 1'b1;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      key_flag_q    <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_state_q   <= 1'b1;
    end else begin
      key_s1_q      <= key_s1_d;
      key_s2_q      <= key_s2_d;
      key_d_q       <= key_d_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_flag_q    <= key_flag_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_state_q   <= key_state_d;
    end
  end

  assign key_flag    = key_flag_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_state   = key_state_q;

endmodule
`default_nettype wire
